// File: rtl/cam_stream_generator.sv
// cam_stream_generator
// On-chip camera stand-in: produces an OV7670-style byte stream (VSYNC, HREF,
// 8-bit data carrying RGB565 high byte first). The pixel source is a CPU-written
// line RAM, repeated on every active line, or an optional colour-bar pattern.
//
// Optional feature macro: CAM_GEN_COLORBAR_EN
//   defined   -> Control bit1 selects 8 vertical colour bars
//   undefined -> bit1 is not stored, output always comes from the line RAM
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   address/read/readdata Avalon-MM slave read (1-cycle latency, registered)
//   write/writedata       Avalon-MM slave write
//   CamVsync              frame sync, active high
//   CamHsync              HREF, high while CamData_out is valid
//   CamData_out           stream byte, 0 while HREF is low
//   frame_done            one-cycle pulse at the end of each frame
//
// Memory map (word addresses):
//   0..639 line RAM {16'h0, rgb565}; 640 Control {pattern, enable};
//   641 Status {enable, busy}; 642 FrameCount[15:0]

module cam_stream_generator #(
    parameter int H_ACTIVE    = 640,
    parameter int H_BLANK     = 144,
    parameter int V_ACTIVE    = 480,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] address,
    input  logic        read,
    output logic [31:0] readdata,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic        CamVsync,
    output logic        CamHsync,
    output logic [7:0]  CamData_out,
    output logic        frame_done
);

    localparam int RAM_DEPTH = 640;
    localparam int PW        = 10;
    localparam int LINE_LEN  = 2 * H_ACTIVE + H_BLANK;
    localparam int BW        = $clog2(LINE_LEN);
    localparam int LW        = $clog2(V_ACTIVE + VSYNC_LINES + V_BACK + V_FRONT + 1);

    localparam logic [BW-1:0] BYTE_LAST = BW'(LINE_LEN - 1);
    localparam logic [BW-1:0] BYTE_ACT  = BW'(2 * H_ACTIVE);
    localparam logic [10:0]   ADDR_RAM_END = 11'd640;
    localparam logic [10:0]   ADDR_CTRL    = 11'd640;
    localparam logic [10:0]   ADDR_STAT    = 11'd641;
    localparam logic [10:0]   ADDR_FCNT    = 11'd642;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFRONT = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    state_t          state_r, state_nxt_s, phase_after_s;
    logic [BW-1:0]   byte_cnt_r, byte_cnt_nxt_s;
    logic [LW-1:0]   line_cnt_r, line_cnt_nxt_s, lines_last_s;
    logic            frame_start_s;
    logic            ctrl_enable_r;
    logic            pattern_bit_s;
    logic [15:0]     frame_count_r;
    logic            busy_s;
    logic [31:0]     reg_rd_s;
    logic [15:0]     line_ram [RAM_DEPTH];
    logic [PW-1:0]   pix_idx_s;
    logic            stream_rd_s;
    logic [15:0]     ram_q_r;
    logic            vsync_s1_r, href_s1_r, odd_s1_r, done_s1_r;
    logic [15:0]     pix_s;
    logic [7:0]      data_s;
    logic            unused_s;

    assign unused_s = ^writedata[31:16];

    // Colour-bar lookup: bar index 0..7 to RGB565 value
    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_color = 16'hFFFF;
            3'd1:    bar_color = 16'hFFE0;
            3'd2:    bar_color = 16'h07FF;
            3'd3:    bar_color = 16'h07E0;
            3'd4:    bar_color = 16'hF81F;
            3'd5:    bar_color = 16'hF800;
            3'd6:    bar_color = 16'h001F;
            default: bar_color = 16'h0000;
        endcase
    endfunction

`ifdef CAM_GEN_COLORBAR_EN
    logic        ctrl_pattern_r;
    logic        pattern_r;
    logic [15:0] bar_s1_r;
    logic [2:0]  bar_idx_s;
    assign pattern_bit_s = ctrl_pattern_r;
    assign bar_idx_s     = 3'((int'(pix_idx_s) * 32'sd8) / H_ACTIVE);

    // Pattern select is frozen at frame start so a frame never mixes sources
    always_ff @(posedge clk) begin
        if (reset) begin
            pattern_r <= 1'b0;
            bar_s1_r  <= 16'h0000;
        end else begin
            if (frame_start_s) begin
                pattern_r <= ctrl_pattern_r;
            end
            bar_s1_r <= bar_color(bar_idx_s);
        end
    end
`else
    assign pattern_bit_s = 1'b0;
`endif

    assign busy_s      = (state_r != ST_IDLE);
    assign pix_idx_s   = PW'(byte_cnt_r >> 1);
    assign stream_rd_s = (state_r == ST_ACTIVE) && (byte_cnt_r < BYTE_ACT);

    // Per-phase line budget and the phase that follows it
    always_comb begin
        lines_last_s  = '0;
        phase_after_s = ST_IDLE;
        case (state_r)
            ST_VSYNC:  begin lines_last_s = LW'(VSYNC_LINES - 1); phase_after_s = ST_VBACK;  end
            ST_VBACK:  begin lines_last_s = LW'(V_BACK - 1);      phase_after_s = ST_ACTIVE; end
            ST_ACTIVE: begin lines_last_s = LW'(V_ACTIVE - 1);    phase_after_s = ST_VFRONT; end
            ST_VFRONT: begin lines_last_s = LW'(V_FRONT - 1);     phase_after_s = ST_DONE;   end
            default:   begin lines_last_s = '0;                   phase_after_s = ST_IDLE;   end
        endcase
    end

    // Next-state logic: byte/line counters walk each phase, IDLE/DONE decide on enable
    always_comb begin
        state_nxt_s    = state_r;
        byte_cnt_nxt_s = byte_cnt_r;
        line_cnt_nxt_s = line_cnt_r;
        frame_start_s  = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                byte_cnt_nxt_s = '0;
                line_cnt_nxt_s = '0;
                if (ctrl_enable_r) begin
                    state_nxt_s   = ST_VSYNC;
                    frame_start_s = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                if (byte_cnt_r == BYTE_LAST) begin
                    byte_cnt_nxt_s = '0;
                    if (line_cnt_r == lines_last_s) begin
                        line_cnt_nxt_s = '0;
                        state_nxt_s    = phase_after_s;
                    end else begin
                        line_cnt_nxt_s = line_cnt_r + 1'b1;
                    end
                end else begin
                    byte_cnt_nxt_s = byte_cnt_r + 1'b1;
                end
            end
        endcase
    end

    // FSM state, counters and the frame counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            byte_cnt_r    <= '0;
            line_cnt_r    <= '0;
            frame_count_r <= 16'h0000;
        end else begin
            state_r    <= state_nxt_s;
            byte_cnt_r <= byte_cnt_nxt_s;
            line_cnt_r <= line_cnt_nxt_s;
            if (state_r == ST_DONE) begin
                frame_count_r <= frame_count_r + 16'h0001;
            end
        end
    end

    // Line RAM write port (contents are intentionally not reset)
    always_ff @(posedge clk) begin
        if (write && (address < ADDR_RAM_END)) begin
            line_ram[address[9:0]] <= writedata[15:0];
        end
    end

    // Register read mux for the Avalon slave
    always_comb begin
        reg_rd_s = 32'h0000_0000;
        case (address)
            ADDR_CTRL: reg_rd_s = {30'h0, pattern_bit_s, ctrl_enable_r};
            ADDR_STAT: reg_rd_s = {30'h0, ctrl_enable_r, busy_s};
            ADDR_FCNT: reg_rd_s = {16'h0000, frame_count_r};
            default:   reg_rd_s = 32'h0000_0000;
        endcase
    end

    // Avalon control register and registered read data
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_enable_r <= 1'b0;
`ifdef CAM_GEN_COLORBAR_EN
            ctrl_pattern_r <= 1'b0;
`endif
            readdata <= 32'h0000_0000;
        end else begin
            if (write && (address == ADDR_CTRL)) begin
                ctrl_enable_r <= writedata[0];
`ifdef CAM_GEN_COLORBAR_EN
                ctrl_pattern_r <= writedata[1];
`endif
            end
            if (read) begin
                if (address < ADDR_RAM_END) begin
                    readdata <= {16'h0000, line_ram[address[9:0]]};
                end else begin
                    readdata <= reg_rd_s;
                end
            end
        end
    end

    // Stage 1: synchronous stream RAM read plus matching-delay timing flags.
    // A write to the same address in this cycle leaves the old value here.
    always_ff @(posedge clk) begin
        if (reset) begin
            ram_q_r    <= 16'h0000;
            vsync_s1_r <= 1'b0;
            href_s1_r  <= 1'b0;
            odd_s1_r   <= 1'b0;
            done_s1_r  <= 1'b0;
        end else begin
            if (stream_rd_s) begin
                ram_q_r <= line_ram[pix_idx_s];
            end
            vsync_s1_r <= (state_r == ST_VSYNC);
            href_s1_r  <= stream_rd_s;
            odd_s1_r   <= byte_cnt_r[0];
            done_s1_r  <= (state_r == ST_DONE);
        end
    end

    // Pixel source selection and byte split (high byte on even bytes)
    always_comb begin
        pix_s = ram_q_r;
`ifdef CAM_GEN_COLORBAR_EN
        if (pattern_r) begin
            pix_s = bar_s1_r;
        end else begin
            pix_s = ram_q_r;
        end
`endif
        if (!href_s1_r) begin
            data_s = 8'h00;
        end else if (odd_s1_r) begin
            data_s = pix_s[7:0];
        end else begin
            data_s = pix_s[15:8];
        end
    end

    // Stage 2: registered stream outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            CamVsync    <= 1'b0;
            CamHsync    <= 1'b0;
            CamData_out <= 8'h00;
            frame_done  <= 1'b0;
        end else begin
            CamVsync    <= vsync_s1_r;
            CamHsync    <= href_s1_r;
            CamData_out <= data_s;
            frame_done  <= done_s1_r;
        end
    end

endmodule

// File: tb/tb_cam_stream_generator.sv
module tb_cam_stream_generator;

    localparam int HA = 8;
    localparam int HB = 4;
    localparam int VA = 2;
    localparam int VS = 1;
    localparam int VB = 1;
    localparam int VF = 1;
    localparam int LL = 2 * HA + HB;
    localparam int FRAME = (VS + VB + VA + VF) * LL;
`ifdef CAM_GEN_COLORBAR_EN
    localparam bit BARS = 1'b1;
`else
    localparam bit BARS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] address;
    logic        read;
    logic [31:0] readdata;
    logic        write;
    logic [31:0] writedata;
    logic        CamVsync;
    logic        CamHsync;
    logic [7:0]  CamData_out;
    logic        frame_done;

    int n_assert = 0;
    int n_fail   = 0;

    logic [15:0] ram_model [HA];
    logic [15:0] bar_tab [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                 16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    always #5 clk = ~clk;

    cam_stream_generator #(
        .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA),
        .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .read(read),
        .readdata(readdata), .write(write), .writedata(writedata),
        .CamVsync(CamVsync), .CamHsync(CamHsync),
        .CamData_out(CamData_out), .frame_done(frame_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic av_write(input logic [10:0] a, input logic [31:0] d);
        address = a; writedata = d; write = 1'b1;
        tick();
        write = 1'b0;
    endtask

    task automatic av_read(input logic [10:0] a, output logic [31:0] d);
        address = a; read = 1'b1;
        tick();
        read = 1'b0;
        d = readdata;
    endtask

    // Expected {vsync, href, data, done} at cycle k after the VSYNC rise
    function automatic logic [10:0] exp_vec(int k, bit bars, bit en_after);
        int line, col, p;
        logic v, h;
        logic [7:0] b;
        logic [15:0] px;
        if (k == FRAME) return {2'b00, 8'h00, 1'b1};
        if (k > FRAME) return {en_after, 10'h000};
        line = k / LL;
        col  = k % LL;
        v = (line < VS);
        h = (line >= VS + VB) && (line < VS + VB + VA) && (col < 2 * HA);
        b = 8'h00;
        if (h) begin
            p  = col / 2;
            px = bars ? bar_tab[p / (HA / 8)] : ram_model[p];
            b  = (col % 2 == 0) ? px[15:8] : px[7:0];
        end
        return {v, h, b, 1'b0};
    endfunction

    // Waits for a VSYNC rise, then checks the whole frame cycle by cycle
    task automatic check_frame(input bit clear_mid, input bit bars, input bit en_after);
        logic prev;
        bit found;
        prev  = CamVsync;
        found = 1'b0;
        for (int g = 0; g < 400 && !found; g++) begin
            tick();
            found = (prev === 1'b0) && (CamVsync === 1'b1);
            prev  = CamVsync;
        end
        check("vsync_rise_found", 32'(found), 32'd1);
        if (found) begin
            for (int k = 0; k <= FRAME + 1; k++) begin
                if (k > 0) begin
                    address = 11'd640; writedata = 32'h0;
                    write = clear_mid && (k == 50);
                    tick();
                    write = 1'b0;
                end
                check($sformatf("frame_k%0d", k),
                      32'({CamVsync, CamHsync, CamData_out, frame_done}),
                      32'(exp_vec(k, bars, en_after)));
            end
        end
    endtask

    initial begin
        logic [31:0] rd;
        int evt;
        bit got;
        reset = 1'b1; read = 1'b0; write = 1'b0; address = 11'd0; writedata = 32'h0;
        tick(); tick(); tick();
        check("reset_outputs", 32'({CamVsync, CamHsync, CamData_out, frame_done}), 32'd0);
        reset = 1'b0;

        // Reset with the generator running
        av_write(11'd640, 32'h1);
        for (int i = 0; i < 8; i++) tick();
        check("vsync_before_reset", 32'(CamVsync), 32'd1);
        reset = 1'b1;
        tick();
        check("reset_mid_outputs", 32'({CamVsync, CamHsync, CamData_out, frame_done}), 32'd0);
        check("reset_readdata", readdata, 32'd0);
        reset = 1'b0;
        av_read(11'd641, rd); check("status_after_reset", rd, 32'd0);
        av_read(11'd642, rd); check("fcount_after_reset", rd, 32'd0);
        av_read(11'd640, rd); check("ctrl_after_reset", rd, 32'd0);

        // Line RAM load, upper bits of writedata carry junk
        ram_model[0] = 16'hF800; ram_model[1] = 16'h07E0; ram_model[2] = 16'h001F;
        for (int i = 3; i < HA; i++) ram_model[i] = 16'($urandom);
        for (int i = 0; i < HA; i++) av_write(11'(i), {16'($urandom), ram_model[i]});
        av_read(11'd1, rd);   check("ram1_readback", rd, 32'h0000_07E0);
        av_read(11'd700, rd); check("unmapped_read", rd, 32'd0);
        av_write(11'd641, 32'hFFFF_FFFF);
        av_read(11'd641, rd); check("status_ro", rd, 32'd0);

        // Frame 1 from the line RAM, enable stays set
        av_write(11'd640, 32'h1);
        check_frame(1'b0, 1'b0, 1'b1);

        // Frame 2 is in VSYNC now: reload RAM, request bars for frame 3
        av_read(11'd642, rd); check("fcount_1", rd, 32'd1);
        av_read(11'd641, rd); check("status_busy", rd, 32'd3);
        for (int i = 0; i < HA; i++) ram_model[i] = 16'($urandom);
        for (int i = 0; i < HA; i++) av_write(11'(i), {16'h0, ram_model[i]});
        av_write(11'd640, 32'h3);
        av_read(11'd640, rd); check("ctrl_readback", rd, BARS ? 32'd3 : 32'd1);

        // Frame 3, enable cleared mid-active: frame completes, then idle
        check_frame(1'b1, BARS, 1'b0);
        evt = 0;
        for (int i = 0; i < 250; i++) begin
            tick();
            if (CamVsync || frame_done) evt++;
        end
        check("no_activity_after_clear", 32'(evt), 32'd0);
        av_read(11'd641, rd); check("status_idle", rd, 32'd0);
        av_read(11'd642, rd); check("fcount_3", rd, 32'd3);

        // FrameCount wrap
        force dut.frame_count_r = 16'hFFFF;
        tick();
        release dut.frame_count_r;
        av_read(11'd642, rd); check("fcount_preload", rd, 32'h0000_FFFF);
        av_write(11'd640, 32'h1);
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin tick(); got = (frame_done === 1'b1); end
        check("wrap_done_seen", 32'(got), 32'd1);
        av_read(11'd642, rd); check("fcount_wrap", rd, 32'd0);
        av_write(11'd640, 32'h0);
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin tick(); got = (frame_done === 1'b1); end
        check("last_done_seen", 32'(got), 32'd1);
        tick(); tick(); tick();
        av_read(11'd642, rd); check("fcount_after_wrap", rd, 32'd1);
        av_read(11'd641, rd); check("status_final", rd, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
